// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, word bit
// positions, field legality masks and FSM state encodings.
package instr_encoder_pkg;

   localparam logic [3:0] OP_IDLE = 4'd0;
   localparam logic [3:0] OP_NOP  = 4'd1;
   localparam logic [3:0] OP_RSET = 4'd2;
   localparam logic [3:0] OP_LOAD = 4'd3;
   localparam logic [3:0] OP_STOR = 4'd4;
   localparam logic [3:0] OP_MVAR = 4'd5;
   localparam logic [3:0] OP_MVAO = 4'd6;
   localparam logic [3:0] OP_MVAI = 4'd7;
   localparam logic [3:0] OP_INC  = 4'd8;
   localparam logic [3:0] OP_ADD  = 4'd9;
   localparam logic [3:0] OP_SFTR = 4'd10;
   localparam logic [3:0] OP_SFTL = 4'd11;
   localparam logic [3:0] OP_JUMP = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;
   localparam logic [3:0] OP_DIV  = 4'd14;
   localparam logic [3:0] OP_SUB  = 4'd15;

   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 28;
   localparam int J_BIT     = 27;
   localparam int N_BIT     = 18;
   localparam int Z_BIT     = 17;
   localparam int OPERAND_W = 16;

   // Bit i set => opcode i may carry that field.
   // J: NOP, LOAD, STOR, MVAR, MVAI, ADD, MUL, DIV, SUB
   localparam logic [15:0] J_OK   = 16'hE2BA;
   // N/Z: JUMP only
   localparam logic [15:0] NZ_OK  = 16'h1000;
   // operand: everything except IDLE, NOP, RSET, INC, SFTR, SFTL
   localparam logic [15:0] OPR_OK = 16'hF2F8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCEPT = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_FULL   = 3'd4;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the canonical 32-bit word (illegal
// bits dropped) and flags whether any illegal field bit was presented.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]           op,
   input  logic                 j,
   input  logic                 n,
   input  logic                 z,
   input  logic [OPERAND_W-1:0] operand,
   output logic [31:0]          word,
   output logic                 illegal
);

   // Mask fields by opcode legality and place them at fixed bit positions
   always_comb begin
      word = '0;
      word[OPC_MSB:OPC_LSB] = op;
      word[J_BIT]           = j & J_OK[op];
      word[N_BIT]           = n & NZ_OK[op];
      word[Z_BIT]           = z & NZ_OK[op];
      word[OPERAND_W-1:0]   = OPR_OK[op] ? operand : '0;
      illegal = (j & ~J_OK[op]) |
                ((n | z) & ~NZ_OK[op]) |
                ((operand != '0) & ~OPR_OK[op]);
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field sets over a valid/ready handshake and
// writes canonical words to instruction memory from base_addr upward.
// Optional build macro ENC_STRICT_EN: illegal field sets are dropped
// (accepted but not written) instead of being canonicalized and written.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        op,
   input  logic              j,
   input  logic              n,
   input  logic              z,
   input  logic [15:0]       operand,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              full,
   output logic              err
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       word_q,  word_d;
   logic              ill_q,   ill_d;
   logic              last_q,  last_d;
   logic              err_q,   err_d;

   logic [31:0]       pk_word;
   logic              pk_ill;
   logic              keep;

   instr_pack u_pack (
      .op      (op),
      .j       (j),
      .n       (n),
      .z       (z),
      .operand (operand),
      .word    (pk_word),
      .illegal (pk_ill)
   );

`ifdef ENC_STRICT_EN
   assign keep = ~ill_q;
`else
   assign keep = 1'b1;
`endif

   // Next-state: start handling, handshake capture, write bookkeeping
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      word_d  = word_q;
      ill_d   = ill_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_FULL: begin
            if (start) begin
               ptr_d   = base_addr;
               count_d = '0;
               err_d   = 1'b0;
               state_d = (32'(base_addr) >= 32'(DEPTH)) ? ST_FULL : ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (in_valid) begin
               word_d  = pk_word;
               ill_d   = pk_ill;
               last_d  = in_last;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ill_q) err_d = 1'b1;
            if (keep) begin
               ptr_d   = ptr_q + ADDR_W'(1);
               count_d = count_q + (ADDR_W+1)'(1);
            end
            // in_last wins over the end-of-memory stop
            if (last_q)
               state_d = ST_DONE;
            else if (keep && (32'(ptr_q) == 32'(DEPTH - 1)))
               state_d = ST_FULL;
            else
               state_d = ST_ACCEPT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         word_q  <= '0;
         ill_q   <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         word_q  <= word_d;
         ill_q   <= ill_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_ACCEPT);
   assign mem_we    = (state_q == ST_WRITE) & keep;
   assign mem_addr  = ptr_q;
   assign mem_wdata = word_q;
   assign count     = count_q;
   assign done      = (state_q == ST_DONE);
   assign full      = (state_q == ST_FULL);
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus random
// programs, checked against a field-rule reference model and write queue.
module tb_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_last = 1'b0;
   logic [3:0]        op = '0;
   logic              j = 1'b0, n = 1'b0, z = 1'b0;
   logic [15:0]       operand = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              done, full, err;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .op(op), .j(j), .n(n), .z(z), .operand(operand),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .done(done), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
   wr_t exp_q[$];

   int  n_cmp = 0, n_bad = 0;
   int  cyc = 0;
   int  last_wr_cyc = -1;
   bit  spacing_on = 0;
   int  m_ptr = 0, m_cnt = 0;
   bit  m_err = 0, m_done = 0, m_full = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: word layout and legality straight from the field rules
   function automatic void model_word(input logic [3:0] o, input bit jj, nn, zz,
                                      input logic [15:0] opr,
                                      output logic [31:0] w, output bit ill);
      bit j_ok, nz_ok, opr_ok;
      j_ok   = o inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd13, 4'd14, 4'd15};
      nz_ok  = (o == 4'd12);
      opr_ok = !(o inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd11});
      ill = (jj && !j_ok) || ((nn || zz) && !nz_ok) || ((opr != 0) && !opr_ok);
      w = {o, jj & j_ok, 8'h00, nn & nz_ok, zz & nz_ok, 1'b0, opr_ok ? opr : 16'h0};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every strobe must match the next expected write
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) chk("spurious_we", 1, 0);
         else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.addr));
            chk("wr_data", 64'(mem_wdata), 64'(e.data));
         end
         if (spacing_on && last_wr_cyc >= 0) chk("wr_spacing", 64'(cyc - last_wr_cyc), 2);
         last_wr_cyc = cyc;
      end
   end

   task automatic do_start(input int b);
      @(negedge clk);
      base_addr = ADDR_W'(b);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_ptr = b; m_cnt = 0; m_err = 0; m_done = 0; m_full = (b >= DEPTH);
      @(negedge clk);
      chk("start_done", 64'(done), 0);
      chk("start_full", 64'(full), 64'(m_full));
      chk("start_cnt", 64'(count), 0);
      chk("start_err", 64'(err), 0);
      chk("start_rdy", 64'(in_ready), 64'(!m_full));
   endtask

   task automatic send(input logic [3:0] o, input bit jj, nn, zz,
                       input logic [15:0] opr, input bit last, input bit pulse_start);
      int k;
      logic [31:0] w;
      bit ill, keep;
      op = o; j = jj; n = nn; z = zz; operand = opr; in_last = last;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      if (!in_ready) begin
         chk("ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      if (pulse_start) begin start = 1'b1; base_addr = ADDR_W'($urandom_range(0, 255)); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      start = 1'b0;
      model_word(o, jj, nn, zz, opr, w, ill);
      keep = 1;
`ifdef ENC_STRICT_EN
      keep = !ill;
`endif
      m_err |= ill;
      if (keep) exp_q.push_back('{addr: ADDR_W'(m_ptr), data: w});
      if (last) m_done = 1;
      else if (keep && m_ptr == DEPTH - 1) m_full = 1;
      if (keep) begin m_ptr++; m_cnt++; end
   endtask

   task automatic end_check(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, 64'(done), 64'(m_done));
      chk({tag, "_full"}, 64'(full), 64'(m_full));
      chk({tag, "_count"}, 64'(count), 64'(m_cnt));
      chk({tag, "_err"}, 64'(err), 64'(m_err));
      chk({tag, "_pending"}, 64'(exp_q.size()), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rdy", 64'(in_ready), 0);
      chk("rst_we", 64'(mem_we), 0);
      chk("rst_addr", 64'(mem_addr), 0);
      chk("rst_wdata", 64'(mem_wdata), 0);
      chk("rst_cnt", 64'(count), 0);
      chk("rst_flags", 64'({done, full, err}), 0);
      rst = 1'b0;

      // basic two-word program
      do_start(16'h10);
      send(4'd3, 1, 0, 0, 16'h0042, 0, 0);
      send(4'd9, 0, 0, 0, 16'h0005, 1, 0);
      end_check("t1");

      // JUMP condition bits, then RSET with operand that must be cleared
      do_start(16'h20);
      send(4'd12, 0, 1, 0, 16'h0020, 0, 0);
      send(4'd2, 0, 0, 0, 16'hFFFF, 1, 0);
      end_check("t2");

      // illegal J on INC between two legal words
      do_start(16'h30);
      send(4'd4, 1, 0, 0, 16'h1234, 0, 0);
      send(4'd8, 1, 0, 0, 16'h0000, 0, 0);
      send(4'd15, 0, 0, 0, 16'h00FF, 1, 0);
      end_check("t3");

      // end of memory: two writes, third not accepted
      do_start(DEPTH - 2);
      send(4'd5, 0, 0, 0, 16'h0001, 0, 0);
      send(4'd6, 0, 0, 0, 16'h0002, 0, 0);
      op = 4'd7; operand = 16'h0003; in_valid = 1'b1; in_last = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (in_ready) chk("full_ready", 1, 0);
      end
      in_valid = 1'b0;
      end_check("t4");

      // in_last on the final slot ends with done, not full
      do_start(DEPTH - 1);
      send(4'd1, 0, 0, 0, 16'h0000, 1, 0);
      end_check("t4b");

      // base beyond depth: full immediately, no writes
      do_start(DEPTH + 10);
      end_check("t4c");

      // reset during the WRITE cycle discards the word
      do_start(16'h40);
      op = 4'd13; j = 1; n = 1; z = 0; operand = 16'hBEEF; in_last = 1'b0; in_valid = 1'b1;
      begin
         int k = 0;
         while (!in_ready && k < 20) begin @(negedge clk); k++; end
      end
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_we", 64'(mem_we), 0);
      chk("mid_rst_rdy", 64'(in_ready), 0);
      chk("mid_rst_addr", 64'(mem_addr), 0);
      chk("mid_rst_wdata", 64'(mem_wdata), 0);
      chk("mid_rst_cnt", 64'(count), 0);
      chk("mid_rst_flags", 64'({done, full, err}), 0);
      rst = 1'b0;
      m_ptr = 0; m_cnt = 0; m_err = 0; m_done = 0; m_full = 0;
      end_check("t5");

      // held valid with start pulses during ACCEPT: ignored, 1 word / 2 cycles
      do_start(16'h50);
      spacing_on = 1; last_wr_cyc = -1;
      for (int i = 0; i < 8; i++)
         send(4'($urandom_range(0, 15)), 0, 0, 0, 16'h0000, i == 7, 1);
      @(negedge clk); @(negedge clk);
      spacing_on = 0;
      end_check("t6");

      // random programs
      for (int r = 0; r < 4; r++) begin
         int len;
         do_start($urandom_range(0, 150));
         len = $urandom_range(8, 20);
         for (int i = 0; i < len; i++)
            send(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom),
                 i == len - 1, 0);
         end_check("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
